// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between the control unit and the PC sequencer.
//   Control side (master) drives:
//     PCWre, PCSrc, immediate, jrAddr, jumpAddr, Halt
//   Sequencer side (slave) drives:
//     PC, PC4, nextPC, halted, fault, faultPC, updCnt
//   CNT_W sets the width of updCnt and must match the sequencer's CNT_W.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             PCWre;
  logic [1:0]       PCSrc;
  logic [31:0]      immediate;
  logic [31:0]      jrAddr;
  logic [31:0]      jumpAddr;
  logic             Halt;
  logic [31:0]      PC;
  logic [31:0]      PC4;
  logic [31:0]      nextPC;
  logic             halted;
  logic             fault;
  logic [31:0]      faultPC;
  logic [CNT_W-1:0] updCnt;

  modport master (
    output PCWre, PCSrc, immediate, jrAddr, jumpAddr, Halt,
    input  PC, PC4, nextPC, halted, fault, faultPC, updCnt
  );

  modport slave (
    input  PCWre, PCSrc, immediate, jrAddr, jumpAddr, Halt,
    output PC, PC4, nextPC, halted, fault, faultPC, updCnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and next-PC sequencer.
//   CLK    : rising-edge clock
//   Reset  : asynchronous active-high reset (PC <= RESET_PC, RUN, flags/counters clear)
//   bus    : pc_sequencer_if.slave
//     in : PCWre (commit strobe), PCSrc (00 PC+4, 01 branch, 10 jr, 11 jump),
//          immediate (word offset), jrAddr, jumpAddr, Halt
//     out: PC, PC4, nextPC (combinational candidate), halted, fault,
//          faultPC (PC when fault was taken), updCnt (committed updates)
// A commit to a non-word-aligned candidate traps into FAULT instead of updating
// the PC. HALT and FAULT are absorbing until Reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          CNT_W    = 32
) (
  input logic         CLK,
  input logic         Reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HALT  = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t           state;
  logic [31:0]      pcReg;
  logic [31:0]      faultPcReg;
  logic [CNT_W-1:0] updCntReg;
  logic             haltedReg;
  logic             faultReg;

  logic [31:0]      pc4;
  logic [31:0]      immShift;
  logic [31:0]      candidate;

  // Next-PC candidate selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc4       = pcReg + 32'd4;
    immShift  = bus.immediate << 2;
    candidate = pc4;
    case (bus.PCSrc)
      2'b00:   candidate = pc4;
      2'b01:   candidate = pc4 + immShift;
      2'b10:   candidate = bus.jrAddr;
      2'b11:   candidate = bus.jumpAddr;
      default: candidate = pc4;
    endcase
  end

  // PC register, halt/fault state machine and committed-update counter.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= RUN;
      pcReg      <= RESET_PC;
      faultPcReg <= 32'h00000000;
      updCntReg  <= {CNT_W{1'b0}};
      haltedReg  <= 1'b0;
      faultReg   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.Halt) begin
            // Halt wins over a simultaneous commit.
            state     <= HALT;
            haltedReg <= 1'b1;
          end else if (bus.PCWre) begin
            if (candidate[1:0] == 2'b00) begin
              pcReg     <= candidate;
              updCntReg <= updCntReg + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              state      <= FAULT;
              faultReg   <= 1'b1;
              faultPcReg <= pcReg;
            end
          end else begin
            state <= RUN;
          end
        end
        HALT: begin
          haltedReg <= 1'b1;
        end
        FAULT: begin
          faultReg <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park in FAULT so software sees a trap.
          state      <= FAULT;
          faultReg   <= 1'b1;
          faultPcReg <= pcReg;
        end
      endcase
    end
  end

  assign bus.PC      = pcReg;
  assign bus.PC4     = pc4;
  assign bus.nextPC  = candidate;
  assign bus.halted  = haltedReg;
  assign bus.fault   = faultReg;
  assign bus.faultPC = faultPcReg;
  assign bus.updCnt  = updCntReg;

endmodule
